sdram_pro_arbiter: RTL and testbench
====================================

Name: sdram_pro_arbiter

Overview:
- Central scheduler between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins.
- Owns the auto-refresh interval timer and grants one sub-controller at a time.
- Multiplexes the granted sub-controller's command, bank, address and write-data onto the SDRAM bus.
- The FIFO control layer drives sdram_wr_req / sdram_rd_req into this block.

Parameters:
- REF_CNT_MAX, 750, sys_clk cycles between auto-refresh requests (7.5 us at 100 MHz).
- CNT_W, 10, refresh timer width; must satisfy 2^CNT_W > REF_CNT_MAX.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous reset, active-high
- init_end  in  1  initialisation complete (level)
- init_cmd/init_ba/init_addr  in  4/2/13  init sub-controller bus
- aref_en  out  1  refresh grant
- aref_end  in  1  refresh done (1-cycle pulse)
- aref_cmd/aref_ba/aref_addr  in  4/2/13  refresh sub-controller bus
- sdram_wr_req  in  1  write request (level)
- wr_en  out  1  write grant
- wr_end  in  1  write burst done (pulse)
- wr_cmd/wr_ba/wr_addr  in  4/2/13  write sub-controller bus
- wr_data  in  16  write data
- wr_sdram_en  in  1  write data valid on dq
- sdram_rd_req  in  1  read request (level)
- rd_en  out  1  read grant
- rd_end  in  1  read burst done (pulse)
- rd_cmd/rd_ba/rd_addr  in  4/2/13  read sub-controller bus
- sdram_cke  out  1  tied 1
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins = {cs_n,ras_n,cas_n,we_n}
- sdram_ba  out  2  bank
- sdram_addr  out  13  address
- sdram_dq_out  out  16  dq drive value
- sdram_dq_oe  out  1  dq output enable

Behaviour:
- States: INIT, ARBIT, AREF, WRITE, READ. State is registered.
- Reset: state=INIT, refresh timer=0, aref_pend=0, last_grant=READ. Grants are decoded from state, so all are 0 in reset.
- INIT -> ARBIT on the first cycle init_end=1 is sampled.
- ARBIT grant priority:
  - aref_pend -> AREF
  - else sdram_wr_req -> WRITE
  - else sdram_rd_req -> READ
  - else stay in ARBIT
- Grant decoding: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). At most one grant is high in any cycle.
- Latency: a request sampled in ARBIT at cycle N gives grant high at N+1.
- Release: an end pulse at cycle M returns the state to ARBIT at M+1. End pulses for non-granted owners are ignored.
- No preemption: refresh waits for the current burst's end pulse.
- Refresh timer:
  - Counts only while init_end=1.
  - At count==REF_CNT_MAX the counter returns to 0 and aref_pend is set.
  - aref_pend clears on the ARBIT->AREF transition.
  - If the timer expires again while aref_pend=1, aref_pend stays 1; there is no counting of missed refreshes.
  - If expiry and the grant happen in the same cycle, the set wins and aref_pend remains 1.
- Bus mux (combinational on state):
  - INIT: init bus
  - AREF: aref bus
  - WRITE: wr bus
  - READ: rd bus
  - ARBIT: cmd=4'b0111 (NOP), ba=2'b11, addr=13'h1FFF
- Data path:
  - sdram_dq_out=wr_data always.
  - sdram_dq_oe=wr_sdram_en when state==WRITE, else 0.
- init_end deasserting after INIT has no effect: the state does not return to INIT and the timer holds.
- Reset mid-burst returns state to INIT immediately. Grants drop asynchronously.

Optional Feature:
- Macro: SDRAM_ARB_RR_EN.
- Defined: write/read arbitration in ARBIT is round-robin.
  - When both sdram_wr_req and sdram_rd_req are high, the one not matching last_grant wins.
  - last_grant updates on entry to WRITE or READ.
  - Refresh keeps absolute priority.
- Undefined: fixed priority, write over read. The last_grant register is not built.

Test Plan:
- Hold init_end=0 for 200 cycles, then 1 → state leaves INIT 1 cycle later; all grants stay 0 throughout INIT; sdram_cmd mirrors init_cmd.
- Raise sdram_wr_req and sdram_rd_req together in ARBIT at cycle 10 → wr_en=1 at cycle 11. Pulse wr_end at 20 → state=ARBIT at 21, rd_en=1 at 22. With SDRAM_ARB_RR_EN and both requests held, grants alternate W,R,W,R.
- After init_end, no traffic → aref_en rises every REF_CNT_MAX+1 cycles (751 cycles with default). sdram bus shows 4'b0111/2'b11/13'h1FFF while in ARBIT.
- Start a write at cycle 700 after init_end, hold it past cycle 760 → aref_pend set at 750, wr_en stays high; the cycle after wr_end returns state to ARBIT, aref_en=1 even with sdram_wr_req still high.
- Hold REF_CNT_MAX=20 and a 50-cycle write → exactly one AREF follows, not two.
- Assert sys_rst during READ → rd_en=0 in the same cycle; state=INIT; timer=0; sdram_dq_oe=0.

Source files
------------

// File: rtl/sdram_pro_arbiter.sv
// SDRAM command arbiter: schedules init, auto-refresh, write and read sub-controllers onto the SDRAM pins.
// Define SDRAM_ARB_RR_EN for round-robin write/read arbitration; the default is fixed write-over-read priority.
module sdram_pro_arbiter #(
    parameter int REF_CNT_MAX = 750,
    parameter int CNT_W       = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        sdram_wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_sdram_en,
    input  logic        sdram_rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] REF_MAX = CNT_W'(REF_CNT_MAX);
    localparam logic [3:0]       CMD_NOP = 4'b0111;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ref_cnt;
    logic             aref_pend;
    logic             ref_expire;
    logic             pick_wr;
    logic [3:0]       sdram_cmd;

    assign ref_expire = init_end && (ref_cnt == REF_MAX);

`ifdef SDRAM_ARB_RR_EN
    // Set when the most recent write/read grant went to the write side.
    logic last_wr;

    assign pick_wr = sdram_wr_req && (!sdram_rd_req || !last_wr);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            last_wr <= 1'b0;
        end else if (state == ARBIT) begin
            if (state_nxt == WRITE)
                last_wr <= 1'b1;
            else if (state_nxt == READ)
                last_wr <= 1'b0;
        end
    end
`else
    assign pick_wr = sdram_wr_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= INIT;
        else
            state <= state_nxt;
    end

    // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:  if (init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (aref_pend)
                    state_nxt = AREF;
                else if (pick_wr)
                    state_nxt = WRITE;
                else if (sdram_rd_req)
                    state_nxt = READ;
            end
            AREF:  if (aref_end) state_nxt = ARBIT;
            WRITE: if (wr_end)   state_nxt = ARBIT;
            READ:  if (rd_end)   state_nxt = ARBIT;
            default: state_nxt = INIT;
        endcase
    end

    // The timer freezes whenever init_end is low, including after initialisation.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ref_cnt <= '0;
        end else if (init_end) begin
            if (ref_expire)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // A fresh expiry outranks the clear, so a coincident grant never loses a refresh.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            aref_pend <= 1'b0;
        else if (ref_expire)
            aref_pend <= 1'b1;
        else if (state == ARBIT && state_nxt == AREF)
            aref_pend <= 1'b0;
    end

    assign aref_en = (state == AREF);
    assign wr_en   = (state == WRITE);
    assign rd_en   = (state == READ);

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1FFF;
        case (state)
            INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1FFF;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sdram_cmd;

    assign sdram_cke    = 1'b1;
    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = (state == WRITE) ? wr_sdram_en : 1'b0;

endmodule

// File: tb/tb_sdram_pro_arbiter.sv
// Directed bench for sdram_pro_arbiter with default parameters (REF_CNT_MAX=750).
// Edge indices count from the first edge that samples init_end=1; SDRAM_ARB_RR_EN switches the dual-request expectations.
module tb_sdram_pro_arbiter;

    localparam logic [18:0] INIT_BUS = {4'b0010, 2'b00, 13'h0001};
    localparam logic [18:0] AREF_BUS = {4'b0001, 2'b01, 13'h0002};
    localparam logic [18:0] WR_BUS   = {4'b0100, 2'b10, 13'h0003};
    localparam logic [18:0] RD_BUS   = {4'b0101, 2'b11, 13'h0004};
    localparam logic [18:0] IDLE_BUS = {4'b0111, 2'b11, 13'h1FFF};
    localparam logic [15:0] WDATA    = 16'hA5C3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end;
    logic        aref_en, aref_end;
    logic        sdram_wr_req, wr_en, wr_end, wr_sdram_en;
    logic        sdram_rd_req, rd_en, rd_end;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    logic [18:0] bus;
    logic [2:0]  grants;
    assign bus    = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    assign grants = {aref_en, wr_en, rd_en};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_pro_arbiter dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .init_end     (init_end),
        .init_cmd     (INIT_BUS[18:15]),
        .init_ba      (INIT_BUS[14:13]),
        .init_addr    (INIT_BUS[12:0]),
        .aref_en      (aref_en),
        .aref_end     (aref_end),
        .aref_cmd     (AREF_BUS[18:15]),
        .aref_ba      (AREF_BUS[14:13]),
        .aref_addr    (AREF_BUS[12:0]),
        .sdram_wr_req (sdram_wr_req),
        .wr_en        (wr_en),
        .wr_end       (wr_end),
        .wr_cmd       (WR_BUS[18:15]),
        .wr_ba        (WR_BUS[14:13]),
        .wr_addr      (WR_BUS[12:0]),
        .wr_data      (WDATA),
        .wr_sdram_en  (wr_sdram_en),
        .sdram_rd_req (sdram_rd_req),
        .rd_en        (rd_en),
        .rd_end       (rd_end),
        .rd_cmd       (RD_BUS[18:15]),
        .rd_ba        (RD_BUS[14:13]),
        .rd_addr      (RD_BUS[12:0]),
        .sdram_cke    (sdram_cke),
        .sdram_cs_n   (sdram_cs_n),
        .sdram_ras_n  (sdram_ras_n),
        .sdram_cas_n  (sdram_cas_n),
        .sdram_we_n   (sdram_we_n),
        .sdram_ba     (sdram_ba),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, clear of the active edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        int bad;
        logic [2:0] exp_g;

        sys_rst = 1'b1;
        init_end = 1'b0;
        aref_end = 1'b0;
        sdram_wr_req = 1'b0;
        wr_end = 1'b0;
        wr_sdram_en = 1'b0;
        sdram_rd_req = 1'b0;
        rd_end = 1'b0;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_grants", 32'(grants), 32'd0);
        check("rst_bus", 32'(bus), 32'(INIT_BUS));
        check("rst_cke", 32'(sdram_cke), 32'd1);
        check("rst_dq_oe", 32'(sdram_dq_oe), 32'd0);
        sys_rst = 1'b0;

        // init_end low for 200 cycles: no grants, init bus on the pins
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (grants != 3'b000 || bus != INIT_BUS) bad++;
        end
        check("init_hold", 32'(bad), 32'd0);

        init_end = 1'b1;
        #1;
        check("init_still", 32'(bus), 32'(INIT_BUS));
        tick();
        cyc = 0;
        check("init_exit_bus", 32'(bus), 32'(IDLE_BUS));
        check("init_exit_grants", 32'(grants), 32'd0);
        check("dq_out", 32'(sdram_dq_out), 32'(WDATA));

        // both requests at edge 10: write wins
        tick_to(9);
        sdram_wr_req = 1'b1;
        sdram_rd_req = 1'b1;
        tick();
        check("both_wr_first", 32'(grants), 32'b010);
        check("wr_bus", 32'(bus), 32'(WR_BUS));
        wr_sdram_en = 1'b1;
        #1;
        check("wr_dq_oe", 32'(sdram_dq_oe), 32'd1);

        tick_to(12);
        rd_end = 1'b1;
        aref_end = 1'b1;
        tick();
        rd_end = 1'b0;
        aref_end = 1'b0;
        check("foreign_end_ignored", 32'(grants), 32'b010);

        tick_to(19);
        wr_end = 1'b1;
        sdram_wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        check("wr_release_bus", 32'(bus), 32'(IDLE_BUS));
        check("wr_release_grants", 32'(grants), 32'd0);
        tick();
        check("rd_grant", 32'(grants), 32'b001);
        check("rd_bus", 32'(bus), 32'(RD_BUS));
        check("rd_dq_oe", 32'(sdram_dq_oe), 32'd0);
        wr_sdram_en = 1'b0;

        tick_to(29);
        rd_end = 1'b1;
        sdram_rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
        check("rd_release", 32'(grants), 32'd0);

        // both held: alternation under round-robin, write every time otherwise
        sdram_wr_req = 1'b1;
        sdram_rd_req = 1'b1;
        tick();
        check("both_g1", 32'(grants), 32'b010);
        tick_to(34);
        wr_end = 1'b1;
        rd_end = 1'b1;
        tick();
        wr_end = 1'b0;
        rd_end = 1'b0;
        tick();
`ifdef SDRAM_ARB_RR_EN
        exp_g = 3'b001;
`else
        exp_g = 3'b010;
`endif
        check("both_g2", 32'(grants), 32'(exp_g));
        tick_to(39);
        wr_end = 1'b1;
        rd_end = 1'b1;
        tick();
        wr_end = 1'b0;
        rd_end = 1'b0;
        tick();
        check("both_g3", 32'(grants), 32'b010);
        tick_to(44);
        wr_end = 1'b1;
        rd_end = 1'b1;
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
        tick();
        wr_end = 1'b0;
        rd_end = 1'b0;
        tick_to(100);
        check("idle_bus", 32'(bus), 32'(IDLE_BUS));
        check("idle_grants", 32'(grants), 32'd0);

        // write from edge 700 held across the first expiry at edge 750
        tick_to(699);
        sdram_wr_req = 1'b1;
        tick();
        check("wr_700", 32'(grants), 32'b010);
        tick_to(751);
        check("wr_no_preempt", 32'(grants), 32'b010);
        tick_to(769);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        check("wr_770_release", 32'(grants), 32'd0);
        tick();
        check("aref_over_wr", 32'(grants), 32'b100);
        check("aref_bus", 32'(bus), 32'(AREF_BUS));
        tick_to(774);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        tick();
        check("wr_resume", 32'(grants), 32'b010);

        // long write spanning expiries at 1501 and 2252: only one refresh afterwards
        tick_to(2299);
        wr_end = 1'b1;
        sdram_wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        tick();
        check("single_aref_a", 32'(grants), 32'b100);
        tick_to(2304);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        tick_to(2310);
        check("single_aref_b", 32'(grants), 32'd0);

        // idle refresh cadence: expiries at 3003 and 3754
        tick_to(3003);
        check("aref_3003", 32'(grants), 32'd0);
        tick();
        check("aref_3004", 32'(grants), 32'b100);
        tick_to(3009);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        tick_to(3754);
        check("aref_3754", 32'(grants), 32'd0);
        tick();
        check("aref_3755", 32'(grants), 32'b100);
        tick_to(3759);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;

        // init_end low for 100 edges: stays out of INIT, timer holds (next expiry 4605)
        tick_to(3769);
        init_end = 1'b0;
        tick_to(3869);
        check("init_drop_bus", 32'(bus), 32'(IDLE_BUS));
        init_end = 1'b1;
        tick_to(4605);
        check("timer_held_a", 32'(grants), 32'd0);
        tick();
        check("timer_held_b", 32'(grants), 32'b100);
        tick_to(4609);
        aref_end = 1'b1;
        tick();
        aref_end = 1'b0;

        // reset during a read
        tick_to(4611);
        sdram_rd_req = 1'b1;
        tick();
        check("rd_before_rst", 32'(grants), 32'b001);
        tick_to(4614);
        wr_sdram_en = 1'b1;
        #3;
        sys_rst = 1'b1;
        #1;
        check("rst_async_grants", 32'(grants), 32'd0);
        check("rst_async_bus", 32'(bus), 32'(INIT_BUS));
        check("rst_async_oe", 32'(sdram_dq_oe), 32'd0);
        sdram_rd_req = 1'b0;
        wr_sdram_en = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        tick();
        cyc = 0;
        check("rst_reinit", 32'(bus), 32'(IDLE_BUS));
        tick_to(750);
        check("rst_timer_a", 32'(grants), 32'd0);
        tick();
        check("rst_timer_b", 32'(grants), 32'b100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
